// File: rtl/pcap_writer.sv
// Packet-to-pcap serializer: emits a pcap global header once after reset, then one
// record header plus buffered payload per captured packet over a pausable byte stream.
module pcap_writer #(
    parameter int MAX_PKT       = 2048,
    parameter int CYCLES_PER_US = 50,
    parameter int LINKTYPE      = 1
) (
    input  logic       CLOCK,
    input  logic       RESETN,
    input  logic       in_available,
    input  logic       in_datavalid,
    input  logic [7:0] in_data,
    input  logic       out_pause,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [7:0] pktcount,
    output logic [7:0] dropcount,
    output logic       busy
);
    localparam int AW = $clog2(MAX_PKT);
    localparam int CW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [31:0] SNAPLEN = 32'(MAX_PKT);
    localparam logic [31:0] LINK    = 32'(LINKTYPE);

    localparam logic [2:0] S_GHDR    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_PHDR    = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [16:0]   idx_q, idx_d;
    logic [31:0]   orig_len_q, orig_len_d;
    logic [31:0]   ts_sec_q, ts_sec_d;
    logic [19:0]   ts_usec_q, ts_usec_d;
    logic [31:0]   sec_q, sec_d;
    logic [19:0]   usec_q, usec_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [7:0]    pktcount_q, pktcount_d;
    logic [7:0]    dropcount_q, dropcount_d;
    logic          avail_prev_q, avail_prev_d;
    logic          ignore_q, ignore_d;

    logic [7:0]    mem [MAX_PKT];
    logic [7:0]    rd_data_q;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   incl_len;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] ghdr_byte(input logic [4:0] i);
        logic [7:0] b;
        case (i[4:2])
            3'd0:    b = byte_of(32'hA1B2C3D4, i[1:0]);
            3'd1:    b = byte_of(32'h00040002, i[1:0]);
            3'd4:    b = byte_of(SNAPLEN, i[1:0]);
            3'd5:    b = byte_of(LINK, i[1:0]);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] phdr_byte(input logic [3:0] i, input logic [31:0] sec,
                                             input logic [19:0] usec, input logic [31:0] incl,
                                             input logic [31:0] orig);
        logic [7:0] b;
        case (i[3:2])
            2'd0:    b = byte_of(sec, i[1:0]);
            2'd1:    b = byte_of({12'd0, usec}, i[1:0]);
            2'd2:    b = byte_of(incl, i[1:0]);
            default: b = byte_of(orig, i[1:0]);
        endcase
        return b;
    endfunction

    assign incl_len = (orig_len_q > SNAPLEN) ? SNAPLEN : orig_len_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        orig_len_d   = orig_len_q;
        ts_sec_d     = ts_sec_q;
        ts_usec_d    = ts_usec_q;
        sec_d        = sec_q;
        usec_d       = usec_q;
        cyc_d        = cyc_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        pktcount_d   = pktcount_q;
        dropcount_d  = dropcount_q;
        avail_prev_d = in_available;
        ignore_d     = ignore_q;
        mem_we       = 1'b0;
        mem_waddr    = orig_len_q[AW-1:0];

        if (cyc_q == CW'(CYCLES_PER_US - 1)) begin
            cyc_d = '0;
            if (usec_q == 20'd999999) begin
                usec_d = 20'd0;
                sec_d  = sec_q + 32'd1;
            end else begin
                usec_d = usec_q + 20'd1;
            end
        end else begin
            cyc_d = cyc_q + CW'(1);
        end

        if (!in_available) begin
            ignore_d = 1'b0;
        end

        case (state_q)
            S_GHDR: begin
                // Extra cycle after the last byte so out_valid is already low once IDLE is reached.
                if (idx_q == 17'd24) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (!out_pause) begin
                    out_valid_d = 1'b1;
                    out_data_d  = ghdr_byte(idx_q[4:0]);
                    idx_d       = idx_q + 17'd1;
                end
            end
            S_IDLE: begin
                if (in_available && !ignore_q) begin
                    state_d    = S_CAPTURE;
                    ts_sec_d   = sec_d;
                    ts_usec_d  = usec_d;
                    orig_len_d = 32'd0;
                    mem_waddr  = '0;
                    if (in_datavalid) begin
                        mem_we     = 1'b1;
                        orig_len_d = 32'd1;
                    end
                end
            end
            S_CAPTURE: begin
                if (in_datavalid) begin
                    orig_len_d = orig_len_q + 32'd1;
                    mem_we     = (orig_len_q < SNAPLEN);
                end
                if (!in_available) begin
                    idx_d   = '0;
                    state_d = (orig_len_d == 32'd0) ? S_IDLE : S_PHDR;
                end
            end
            S_PHDR: begin
                if (!out_pause) begin
                    out_valid_d = 1'b1;
                    out_data_d  = phdr_byte(idx_q[3:0], ts_sec_q, ts_usec_q, incl_len, orig_len_q);
                    if (idx_q == 17'd15) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 17'd1;
                    end
                end
            end
            S_DATA: begin
                if (idx_q == incl_len[16:0]) begin
                    state_d    = S_IDLE;
                    idx_d      = '0;
                    pktcount_d = pktcount_q + 8'd1;
                end else if (!out_pause) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data_q;
                    idx_d       = idx_q + 17'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A packet starting while we are emitting is skipped in full and counted once.
        if ((state_q == S_GHDR || state_q == S_PHDR || state_q == S_DATA) &&
            in_available && !avail_prev_q) begin
            ignore_d = 1'b1;
            if (dropcount_q != 8'hFF) begin
                dropcount_d = dropcount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= S_GHDR;
            idx_q        <= '0;
            orig_len_q   <= '0;
            ts_sec_q     <= '0;
            ts_usec_q    <= '0;
            sec_q        <= '0;
            usec_q       <= '0;
            cyc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            pktcount_q   <= 8'h00;
            dropcount_q  <= 8'h00;
            avail_prev_q <= 1'b0;
            ignore_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            orig_len_q   <= orig_len_d;
            ts_sec_q     <= ts_sec_d;
            ts_usec_q    <= ts_usec_d;
            sec_q        <= sec_d;
            usec_q       <= usec_d;
            cyc_q        <= cyc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            pktcount_q   <= pktcount_d;
            dropcount_q  <= dropcount_d;
            avail_prev_q <= avail_prev_d;
            ignore_q     <= ignore_d;
        end
    end

    // Read address tracks the byte to be emitted after this edge, so rd_data_q is ready in time.
    always_ff @(posedge CLOCK) begin
        if (mem_we) begin
            mem[mem_waddr] <= in_data;
        end
        rd_data_q <= mem[idx_d[AW-1:0]];
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign pktcount  = pktcount_q;
    assign dropcount = dropcount_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pcap_writer.sv
// Directed bench for pcap_writer: a queue of expected stream bytes built from the pcap
// format rules, checked against every valid output byte, plus counter/status spot checks.
module tb_pcap_writer;
    localparam int MAXP = 2048;
    localparam int CPU  = 1;
    localparam int LT   = 1;

    logic       CLOCK;
    logic       RESETN;
    logic       in_available;
    logic       in_datavalid;
    logic [7:0] in_data;
    logic       out_pause;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] pktcount;
    logic [7:0] dropcount;
    logic       busy;

    pcap_writer #(.MAX_PKT(MAXP), .CYCLES_PER_US(CPU), .LINKTYPE(LT)) dut (
        .CLOCK(CLOCK),
        .RESETN(RESETN),
        .in_available(in_available),
        .in_datavalid(in_datavalid),
        .in_data(in_data),
        .out_pause(out_pause),
        .out_valid(out_valid),
        .out_data(out_data),
        .pktcount(pktcount),
        .dropcount(dropcount),
        .busy(busy)
    );

    int         total = 0;
    int         bad = 0;
    int         edges = 0;
    logic [7:0] exp_q[$];
    logic [7:0] hdr_buf [16];
    logic       paused_edge = 1'b0;
    logic       pause_rand = 1'b0;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Rising edges since reset release; the edge that samples a packet start is its timestamp.
    always @(posedge CLOCK) begin
        if (!RESETN) edges = 0;
        else edges = edges + 1;
        paused_edge = RESETN && out_pause;
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        logic [7:0] e;
        if (RESETN) begin
            if (paused_edge) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL pause_hold: out_valid=%0b want 0", out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_byte: got %02h want no byte", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL stream_byte: got %02h want %02h (%0d left)", out_data, e, exp_q.size());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK);
            if (pause_rand) out_pause = ($urandom_range(0, 2) == 0);
        end
    end

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'(i * (2 * seed + 1) + seed);
    endfunction

    function automatic void push_le32(input int unsigned v);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(v >> (8 * k)));
    endfunction

    function automatic void push_ghdr();
        push_le32(32'hA1B2C3D4);
        push_le32(32'h00040002);
        push_le32(0);
        push_le32(0);
        push_le32(MAXP);
        push_le32(LT);
    endfunction

    function automatic void make_phdr(input longint t_edges, input int unsigned orig);
        longint      t;
        int unsigned f [4];
        t    = t_edges / CPU;
        f[0] = int'(t / 1000000);
        f[1] = int'(t % 1000000);
        f[2] = (orig > MAXP) ? MAXP : orig;
        f[3] = orig;
        for (int k = 0; k < 16; k++) hdr_buf[k] = 8'(f[k / 4] >> (8 * (k % 4)));
    endfunction

    function automatic logic [127:0] packed_hdr();
        logic [127:0] p;
        for (int k = 0; k < 16; k++) p[8 * k +: 8] = hdr_buf[k];
        return p;
    endfunction

    function automatic void push_pkt(input int start_edge, input int n, input int seed);
        make_phdr(start_edge, n);
        for (int k = 0; k < 16; k++) exp_q.push_back(hdr_buf[k]);
        for (int i = 0; i < ((n > MAXP) ? MAXP : n); i++) exp_q.push_back(pat(i, seed));
    endfunction

    // Called at a negedge; the following rising edge samples the packet start.
    task automatic send_pkt(input int n, input int seed, input bit gaps, input bit last_low,
                            input bit accept, output int start_edge);
        int i = 0;
        int c = 0;
        start_edge = edges + 1;
        if (accept && n > 0) push_pkt(start_edge, n, seed);
        if (n == 0) begin
            in_available = 1'b1;
            in_datavalid = 1'b0;
            repeat (3) @(negedge CLOCK);
        end else begin
            while (i < n) begin
                in_available = 1'b1;
                if (gaps && (c % 3 == 2)) begin
                    in_datavalid = 1'b0;
                end else begin
                    in_datavalid = 1'b1;
                    in_data      = pat(i, seed);
                    if (last_low && i == n - 1) in_available = 1'b0;
                    i++;
                end
                c++;
                @(negedge CLOCK);
            end
        end
        if (!(last_low && n > 0)) begin
            in_available = 1'b0;
            in_datavalid = 1'b0;
            @(negedge CLOCK);
        end
        in_available = 1'b0;
        in_datavalid = 1'b0;
        in_data      = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < 20000) begin
            @(negedge CLOCK);
            cyc++;
        end
        chk(name, {190'd0, (exp_q.size() != 0), busy}, 192'd0);
    endtask

    task automatic wait_q_below(input int th, input string name);
        int cyc = 0;
        while (exp_q.size() >= th && cyc < 20000) begin
            @(negedge CLOCK);
            cyc++;
        end
        chk(name, 192'(cyc >= 20000), 192'd0);
    endtask

    initial begin
        int se;
        logic [191:0] gh;
        RESETN = 1'b0;
        in_available = 1'b0;
        in_datavalid = 1'b0;
        in_data = 8'h00;
        out_pause = 1'b0;
        #1;
        chk("rst_out_valid", 192'(out_valid), 192'd0);
        chk("rst_out_data", 192'(out_data), 192'd0);
        chk("rst_pktcount", 192'(pktcount), 192'd0);
        chk("rst_dropcount", 192'(dropcount), 192'd0);
        chk("rst_busy", 192'(busy), 192'd1);

        push_ghdr();
        for (int k = 0; k < 24; k++) gh[8 * k +: 8] = exp_q[k];
        chk("model_ghdr", gh, 192'h00000001_00000800_00000000_00000000_00040002_A1B2C3D4);
        repeat (3) @(negedge CLOCK);
        RESETN = 1'b1;

        wait_idle("ghdr_done");
        chk("ghdr_busy", 192'(busy), 192'd0);
        // Stray data strobes without in_available must not start a packet.
        repeat (4) begin
            in_datavalid = 1'b1;
            in_data = 8'hEE;
            @(negedge CLOCK);
            chk("idle_valid", 192'(out_valid), 192'd0);
        end
        in_datavalid = 1'b0;
        in_data = 8'h00;
        while (edges < 99) @(negedge CLOCK);

        make_phdr(100, 60);
        chk("model_phdr60", 192'(packed_hdr()), 192'h0000003C_0000003C_00000064_00000000);
        send_pkt(60, 0, 1'b0, 1'b0, 1'b1, se);
        $display("pkt60 start_edge=%0d", se);
        wait_idle("pkt60_done");
        chk("pkt60_count", 192'(pktcount), 192'd1);

        make_phdr(1, 3000);
        chk("model_phdr3000", 192'(packed_hdr() >> 64), 192'h00000BB8_00000800);
        send_pkt(3000, 1, 1'b1, 1'b0, 1'b1, se);
        $display("pkt3000 start_edge=%0d", se);
        wait_q_below(1500, "big_reach_data");
        out_pause = 1'b1;
        repeat (5) begin
            @(negedge CLOCK);
            chk("pause5_valid", 192'(out_valid), 192'd0);
        end
        out_pause = 1'b0;
        wait_idle("pkt3000_done");
        chk("pkt3000_count", 192'(pktcount), 192'd2);

        pause_rand = 1'b1;
        send_pkt(40, 2, 1'b0, 1'b0, 1'b1, se);
        $display("pktA start_edge=%0d", se);
        wait_q_below(30, "pktA_reach_data");
        send_pkt(20, 3, 1'b0, 1'b0, 1'b0, se);
        $display("pktB (dropped) start_edge=%0d", se);
        wait_idle("pktA_done");
        pause_rand = 1'b0;
        out_pause = 1'b0;
        chk("drop_dropcount", 192'(dropcount), 192'd1);
        chk("drop_pktcount", 192'(pktcount), 192'd3);

        send_pkt(0, 0, 1'b0, 1'b0, 1'b1, se);
        repeat (5) @(negedge CLOCK);
        wait_idle("zero_len_done");
        chk("zero_pktcount", 192'(pktcount), 192'd3);
        chk("zero_dropcount", 192'(dropcount), 192'd1);

        send_pkt(5, 4, 1'b0, 1'b1, 1'b1, se);
        $display("pkt5_lastlow start_edge=%0d", se);
        wait_idle("pkt5_done");
        chk("pkt5_count", 192'(pktcount), 192'd4);

        send_pkt(MAXP, 7, 1'b0, 1'b0, 1'b1, se);
        $display("pkt_max start_edge=%0d", se);
        wait_idle("pktmax_done");
        chk("pktmax_count", 192'(pktcount), 192'd5);

        send_pkt(100, 5, 1'b0, 1'b0, 1'b1, se);
        $display("pkt_reset start_edge=%0d", se);
        wait_q_below(60, "rst_reach_data");
        #2;
        RESETN = 1'b0;
        #1;
        chk("midrst_out_valid", 192'(out_valid), 192'd0);
        chk("midrst_pktcount", 192'(pktcount), 192'd0);
        chk("midrst_dropcount", 192'(dropcount), 192'd0);
        chk("midrst_busy", 192'(busy), 192'd1);
        exp_q.delete();
        push_ghdr();
        @(negedge CLOCK);
        RESETN = 1'b1;
        wait_idle("reghdr_done");
        chk("reghdr_pktcount", 192'(pktcount), 192'd0);

        send_pkt(10, 6, 1'b1, 1'b0, 1'b1, se);
        $display("pkt_after_reset start_edge=%0d", se);
        wait_idle("pkt10_done");
        chk("pkt10_count", 192'(pktcount), 192'd1);
        repeat (5) @(negedge CLOCK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
